// File: rtl/fpu_div_iter_pkg.sv
// Shared definitions for the iterative floating-point divider: FSM states,
// flag bit positions, field layout and the exponent-offset macro.
`ifndef FPU_XOFF
`define FPU_XOFF(nx) ((1 << ((nx) - 1)) - 1)
`endif

package fpu_div_iter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIV   = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } div_state_e;

    // Bit positions inside the 3-bit flags word {invalid, div_by_zero, inexact}
    localparam int FLAG_INVALID  = 2;
    localparam int FLAG_DIV_ZERO = 1;
    localparam int FLAG_INEXACT  = 0;

    localparam int FP_NX = 11;
    localparam int FP_NM = 23;

    typedef struct packed {
        logic             sign;
        logic [FP_NX-1:0] exp;
        logic [FP_NM-1:0] mant;
    } fp_fields_t;

endpackage

// File: rtl/fpu_div_iter_if.sv
// Operand/result handshake bundle for fpu_div_iter; the divider is the slave.
interface fpu_div_iter_if #(
    parameter int NX = 11,
    parameter int NM = 23
);
    localparam int N = NX + NM + 1;

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] res;
    logic [2:0]   flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, res, flags
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, res, flags
    );
endinterface

// File: rtl/fpu_round_rne.sv
// Combinational normalise, round-to-nearest-even and exponent saturation
// applied to the raw quotient produced by the restoring divider.
module fpu_round_rne
    import fpu_div_iter_pkg::*;
#(
    parameter int NX = 11,
    parameter int NM = 23
) (
    input  logic                 sign,
    input  logic [NM+2:0]        quot,
    input  logic                 rem_nz,
    input  logic signed [NX+1:0] exp_in,
    output logic [NX+NM:0]       res,
    output logic [2:0]           flags
);

    localparam logic signed [NX+1:0] EXP_ONE  = (NX+2)'(1);
    localparam logic signed [NX+1:0] EXP_ZERO = (NX+2)'(0);
    localparam logic signed [NX+1:0] EXP_MAX  = (NX+2)'((1 << NX) - 1);

    logic [NM+2:0]        norm_s;
    logic signed [NX+1:0] exp_norm_s;
    logic signed [NX+1:0] exp_rnd_s;
    logic                 guard_s;
    logic                 sticky_s;
    logic                 round_up_s;
    logic [NM:0]          mant_sum_s;
    logic [NM-1:0]        mant_s;

    // Normalise, round and classify the final exponent
    always_comb begin
        norm_s     = quot;
        exp_norm_s = exp_in;
        res        = {(NX+NM+1){1'b0}};
        flags      = 3'b000;

        // Quotient lies in (0.5, 2); a clear MSB means one bit of headroom to remove
        if (quot[NM+2] == 1'b0) begin
            norm_s     = {quot[NM+1:0], 1'b0};
            exp_norm_s = exp_in - EXP_ONE;
        end else begin
            norm_s     = quot;
            exp_norm_s = exp_in;
        end

        guard_s    = norm_s[1];
        sticky_s   = norm_s[0] | rem_nz;
        round_up_s = guard_s & (sticky_s | norm_s[2]);
        mant_sum_s = {1'b0, norm_s[NM+1:2]} + {{NM{1'b0}}, round_up_s};

        if (mant_sum_s[NM]) begin
            mant_s    = {NM{1'b0}};
            exp_rnd_s = exp_norm_s + EXP_ONE;
        end else begin
            mant_s    = mant_sum_s[NM-1:0];
            exp_rnd_s = exp_norm_s;
        end

        if (exp_rnd_s >= EXP_MAX) begin
            res                 = {sign, {NX{1'b1}}, {NM{1'b0}}};
            flags[FLAG_INEXACT] = 1'b1;
        end else if (exp_rnd_s <= EXP_ZERO) begin
            res                 = {sign, {NX{1'b0}}, {NM{1'b0}}};
            flags[FLAG_INEXACT] = 1'b1;
        end else begin
            res                 = {sign, exp_rnd_s[NX-1:0], mant_s};
            flags[FLAG_INEXACT] = guard_s | sticky_s;
        end
    end

endmodule

// File: rtl/fpu_div_iter.sv
// Iterative floating-point divider: one restoring-division quotient bit per
// cycle, a single rounding cycle, and a hold-until-taken result stage.
module fpu_div_iter
    import fpu_div_iter_pkg::*;
#(
    parameter int NX = 11,
    parameter int NM = 23
) (
    input  logic         clk,
    input  logic         rst,
    fpu_div_iter_if.slave bus
);

    localparam int N    = NX + NM + 1;
    localparam int XOFF = `FPU_XOFF(NX);
    localparam int CW   = $clog2(NM + 3);

    localparam logic signed [NX+1:0] XOFF_S   = (NX+2)'(XOFF);
    localparam logic [CW-1:0]        CNT_LAST = CW'(NM + 2);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [NX-1:0]        EXP_ONES = {NX{1'b1}};
    localparam logic [NX-1:0]        EXP_ZERO = {NX{1'b0}};
    localparam logic [NM-1:0]        MANT_ZERO = {NM{1'b0}};
    localparam logic [N-1:0]         QNAN_W   = {1'b0, EXP_ONES, {(NM-1){1'b0}}, 1'b1};

    div_state_e           state_r;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic [N-1:0]         res_r;
    logic [2:0]           flags_r;
    logic [CW-1:0]        cnt_r;
    logic signed [NX+1:0] exp_r;
    logic [NM+1:0]        rem_r;
    logic [NM:0]          dvs_r;
    logic [NM+2:0]        quot_r;
    logic                 sign_r;

    logic          a_sign_s, b_sign_s;
    logic [NX-1:0] a_exp_s, b_exp_s;
    logic [NM-1:0] a_mant_s, b_mant_s;
    logic          a_nan_s, a_inf_s, a_zero_s;
    logic          b_nan_s, b_inf_s, b_zero_s;
    logic          res_sign_s;
    logic          special_s;
    logic [N-1:0]  spec_res_s;
    logic [2:0]    spec_flags_s;
    logic          ge_s;
    logic [NM+1:0] rem_dif_s;
    logic [NM+1:0] rem_sel_s;
    logic [NM+1:0] rem_next_s;
    logic [N-1:0]  rnd_res_s;
    logic [2:0]    rnd_flags_s;

    assign {a_sign_s, a_exp_s, a_mant_s} = bus.a;
    assign {b_sign_s, b_exp_s, b_mant_s} = bus.b;

    assign a_nan_s  = (a_exp_s == EXP_ONES) && (a_mant_s != MANT_ZERO);
    assign a_inf_s  = (a_exp_s == EXP_ONES) && (a_mant_s == MANT_ZERO);
    assign a_zero_s = (a_exp_s == EXP_ZERO);
    assign b_nan_s  = (b_exp_s == EXP_ONES) && (b_mant_s != MANT_ZERO);
    assign b_inf_s  = (b_exp_s == EXP_ONES) && (b_mant_s == MANT_ZERO);
    assign b_zero_s = (b_exp_s == EXP_ZERO);
    assign res_sign_s = a_sign_s ^ b_sign_s;

    // Early-out results for NaN/Inf/zero operands (denormals count as zero)
    always_comb begin
        special_s    = 1'b1;
        spec_res_s   = {N{1'b0}};
        spec_flags_s = 3'b000;
        if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
            spec_res_s                 = QNAN_W;
            spec_flags_s[FLAG_INVALID] = 1'b1;
        end else if (a_inf_s) begin
            spec_res_s = {res_sign_s, EXP_ONES, MANT_ZERO};
        end else if (b_zero_s) begin
            spec_res_s                  = {res_sign_s, EXP_ONES, MANT_ZERO};
            spec_flags_s[FLAG_DIV_ZERO] = 1'b1;
        end else if (a_zero_s || b_inf_s) begin
            spec_res_s = {res_sign_s, EXP_ZERO, MANT_ZERO};
        end else begin
            special_s = 1'b0;
        end
    end

    // One restoring-division step: partial remainder stays below twice the divisor
    always_comb begin
        ge_s       = (rem_r >= {1'b0, dvs_r});
        rem_dif_s  = rem_r - {1'b0, dvs_r};
        if (ge_s) begin
            rem_sel_s = rem_dif_s;
        end else begin
            rem_sel_s = rem_r;
        end
        rem_next_s = rem_sel_s << 1'b1;
    end

    fpu_round_rne #(.NX(NX), .NM(NM)) u_round (
        .sign   (sign_r),
        .quot   (quot_r),
        .rem_nz (|rem_r),
        .exp_in (exp_r),
        .res    (rnd_res_s),
        .flags  (rnd_flags_s)
    );

    // Control FSM with the division datapath and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            res_r       <= {N{1'b0}};
            flags_r     <= 3'b000;
            cnt_r       <= {CW{1'b0}};
            exp_r       <= {(NX+2){1'b0}};
            rem_r       <= {(NM+2){1'b0}};
            dvs_r       <= {(NM+1){1'b0}};
            quot_r      <= {(NM+3){1'b0}};
            sign_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        in_ready_r <= 1'b0;
                        sign_r     <= res_sign_s;
                        exp_r      <= $signed({2'b00, a_exp_s}) - $signed({2'b00, b_exp_s}) + XOFF_S;
                        rem_r      <= {1'b0, 1'b1, a_mant_s};
                        dvs_r      <= {1'b1, b_mant_s};
                        quot_r     <= {(NM+3){1'b0}};
                        cnt_r      <= {CW{1'b0}};
                        if (special_s) begin
                            state_r <= ST_DONE;
                            res_r   <= spec_res_s;
                            flags_r <= spec_flags_s;
                        end else begin
                            state_r <= ST_DIV;
                        end
                    end
                end
                ST_DIV: begin
                    rem_r  <= rem_next_s;
                    quot_r <= {quot_r[NM+1:0], ge_s};
                    cnt_r  <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    res_r   <= rnd_res_s;
                    flags_r <= rnd_flags_s;
                    cnt_r   <= {CW{1'b0}};
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    // Result is presented one edge after entering DONE and held until taken
                    if (out_valid_r && bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.res       = res_r;
    assign bus.flags     = flags_r;

endmodule

// File: doc/fpu_div_iter.md
FPU_DIV_ITER -- requirements
Module: fpu_div_iter

Interface
REQ-001 The module SHALL have parameter NX, default 11, meaning exponent field width.
REQ-002 The module SHALL have parameter NM, default 23, meaning stored mantissa field width.
REQ-003 The module SHALL derive N = NX+NM+1 (word width) and XOFF = 2^(NX-1)-1 (exponent bias).
REQ-004 The module SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The module SHALL have ports in_valid (input, 1) and in_ready (output, 1): operand handshake.
REQ-007 The module SHALL have ports a and b, input, N bits each: dividend and divisor, {sign, exp, mant}.
REQ-008 The module SHALL have ports out_valid (output, 1) and out_ready (input, 1): result handshake.
REQ-009 The module SHALL have port res, output, N bits: quotient.
REQ-010 The module SHALL have port flags, output, 3 bits: {invalid, div_by_zero, inexact}.

Function
REQ-011 States SHALL be IDLE, DIV, ROUND and DONE; in_ready SHALL be 1 only in IDLE.
REQ-012 An accept SHALL occur on an edge with in_valid && in_ready; a and b are registered at that edge.
REQ-013 Exp all-ones with mant != 0 SHALL be NaN; with mant == 0, Inf. Exp == 0 SHALL be zero: denormals flushed, sign kept.
REQ-014 Special cases SHALL go from accept straight to DONE, with out_valid high 1 edge after accept.
REQ-015 Any NaN operand, 0/0 or Inf/Inf SHALL give canonical NaN {0, all-ones, 0..01} with invalid=1.
REQ-016 finite/0 SHALL give Inf with div_by_zero=1.
REQ-017 Inf/finite SHALL give Inf; 0/finite-nonzero and finite/Inf SHALL give zero; no flags.
REQ-018 Result sign SHALL always be sign(a) XOR sign(b), except NaN, whose sign is 0.
REQ-019 Normal operands SHALL enter DIV with exponent E = ea - eb + XOFF, held signed in NX+2 bits.
REQ-020 DIV SHALL run restoring division of {1,ma} by {1,mb}, one quotient bit per cycle, for NM+3 cycles, counted by an iteration counter.
REQ-021 ROUND, 1 cycle: if quotient MSB == 0, shift left 1 and E = E-1.
REQ-022 ROUND SHALL then apply round-to-nearest-even using guard bit and sticky (sticky = lower bits OR remainder != 0).
REQ-023 If rounding overflows the mantissa, ROUND SHALL set mantissa to 0 and E = E+1.
REQ-024 After rounding, E >= 2^NX-1 SHALL give Inf; E <= 0 SHALL give signed zero; both set inexact.
REQ-025 inexact SHALL be 1 whenever guard or sticky is nonzero.
REQ-026 For normal operands, out_valid SHALL rise exactly NM+5 edges after the accepting edge.
REQ-027 In DONE, res and flags SHALL hold stable until an edge with out_ready=1; the module then returns to IDLE.
REQ-028 The next accept SHALL be possible no earlier than the edge after that out_ready edge; there is no overlap of operations.
REQ-029 Input changes while not in IDLE SHALL have no effect.

Reset
REQ-030 rst=1 at an edge SHALL force IDLE, in_ready=1, out_valid=0, res=0, flags=0 and iteration counter=0 at the next edge, including mid-DIV or mid-DONE.
REQ-031 An operation in flight at reset SHALL be discarded with no output produced.

Structure
REQ-032 A shared package SHALL hold the state enum, the flag bit indices, and the IEEE754-style field struct and exponent-offset macro already used by fpu.
REQ-033 One sub-module, fpu_round_rne, SHALL be natural: combinational normalise, round and exponent-saturate logic; the division datapath stays inline.

Verification
REQ-034 6.0/2.0 (a={0,XOFF+2,1<<(NM-1)}, b={0,XOFF+1,0}) -> res={0,XOFF+1,1<<(NM-1)} after NM+5 edges, flags=000.
REQ-035 1.0/3.0 (NM=23) -> res={0,XOFF-2,23'h2AAAAB}, inexact=1; this checks round-up.
REQ-036 5.0/0 -> {0,all-ones,0} with div_by_zero=1, 1 edge latency; 0/0 -> canonical NaN with invalid=1.
REQ-037 Overflow check: max-exponent operand divided by tiny normal -> Inf with inexact=1. Underflow check: tiny divided by huge -> signed zero.
REQ-038 out_ready held 0 for 10 cycles -> res/flags stable, in_ready=0; a second operand offered meanwhile is accepted only after the release.
REQ-039 rst pulsed at DIV cycle 5 -> next edge IDLE and out_valid=0; a following 6.0/2.0 gives the correct result.
